// File: rtl/video_pll_reset_sequencer.sv
// video_pll_reset_sequencer
//   Drives the video PLL reset from the reference-clock side, watches the PLL
//   lock output, and releases the video-domain reset only once lock has been
//   stable for STABLE_CYCLES. Retries the PLL on lock timeout, restarts it on
//   lock loss, and keeps saturating retry/loss counters.
//
// Optional feature macro: PLL_RETRY_LIMIT_EN
//   defined   -> after MAX_RETRIES lock timeouts the block parks in FAIL
//                (PLL held in reset, fail=1) until rst.
//   undefined -> retries are unlimited and fail is tied to 0.
//
// Ports
//   refclk      in   reference clock, the only clock
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock output (asynchronous, synchronised here)
//   pll_rst     out  PLL reset, active high
//   video_rst   out  pixel-domain reset, active high
//   ready       out  PLL locked and stable, video released
//   retry_cnt   out  lock-timeout retries since rst (saturating)
//   lost_cnt    out  lock losses while running since rst (saturating)
//   fail        out  retry limit reached
module video_pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] lost_cnt,
  output logic       fail
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
  localparam int unsigned CW      = 8;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3
`ifdef PLL_RETRY_LIMIT_EN
    ,ST_FAIL     = 3'd4
`endif
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [CW-1:0] r_retry_cnt;
  logic [CW-1:0] w_retry_nxt;
  logic [CW-1:0] w_retry_inc;
  logic [CW-1:0] r_lost_cnt;
  logic [CW-1:0] w_lost_nxt;
  logic [CW-1:0] w_lost_inc;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_lock_s;
  logic          r_pll_rst;
  logic          r_video_rst;
  logic          r_ready;
  logic          w_pll_rst_nxt;
  logic          w_run_nxt;

  // Two-flop synchroniser for the asynchronous lock signal
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_s = r_sync2;

  // Saturating increments
  assign w_retry_inc = (r_retry_cnt == {CW{1'b1}}) ? r_retry_cnt : r_retry_cnt + CW'(1);
  assign w_lost_inc  = (r_lost_cnt  == {CW{1'b1}}) ? r_lost_cnt  : r_lost_cnt  + CW'(1);

  // Next-state, timer and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + TW'(1);
    w_retry_nxt = r_retry_cnt;
    w_lost_nxt  = r_lost_cnt;
    case (r_state)
      ST_RST_PLL: begin
        if (r_timer == TW'(RST_CYCLES - 1)) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_timer_nxt = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is checked first so a lock in the timeout cycle wins
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
          w_timer_nxt = '0;
        end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
          w_retry_nxt = w_retry_inc;
          w_timer_nxt = '0;
`ifdef PLL_RETRY_LIMIT_EN
          w_state_nxt = (w_retry_inc >= CW'(MAX_RETRIES)) ? ST_FAIL : ST_RST_PLL;
`else
          w_state_nxt = ST_RST_PLL;
`endif
        end
      end
      ST_STABLE: begin
        // A lock drop here just restarts the lock wait; not a retry or loss
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_timer == TW'(STABLE_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_timer_nxt = '0;
        end
      end
      ST_RUN: begin
        w_timer_nxt = '0;
        if (!w_lock_s) begin
          w_lost_nxt  = w_lost_inc;
          w_state_nxt = ST_RST_PLL;
        end
      end
`ifdef PLL_RETRY_LIMIT_EN
      ST_FAIL: begin
        w_timer_nxt = '0;
      end
`endif
      default: begin
        w_state_nxt = ST_RST_PLL;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    w_pll_rst_nxt = (w_state_nxt == ST_RST_PLL);
`ifdef PLL_RETRY_LIMIT_EN
    if (w_state_nxt == ST_FAIL) begin
      w_pll_rst_nxt = 1'b1;
    end
`endif
    w_run_nxt = (w_state_nxt == ST_RUN);
  end

  // State, timer, counters and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_RST_PLL;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_lost_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_video_rst <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_lost_cnt  <= w_lost_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_video_rst <= !w_run_nxt;
      r_ready     <= w_run_nxt;
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  logic r_fail;

  // Sticky failure flag, cleared only by rst
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_fail <= 1'b0;
    end else begin
      r_fail <= (w_state_nxt == ST_FAIL);
    end
  end

  assign fail = r_fail;
`else
  // The retry limit only matters when the limit feature is built in
  logic w_unused_max_retries;
  assign w_unused_max_retries = ^CW'(MAX_RETRIES);
  assign fail = 1'b0;
`endif

  assign pll_rst   = r_pll_rst;
  assign video_rst = r_video_rst;
  assign ready     = r_ready;
  assign retry_cnt = r_retry_cnt;
  assign lost_cnt  = r_lost_cnt;

endmodule
